// File: rtl/marx_cpu_req_buffer_if.sv
// Core-side request/result and shared-unit request/result signals of one per-core buffer.
// The buffer itself takes the slave view; the surrounding core and shared unit take the master view.
interface marx_cpu_req_buffer_if #(
  parameter int WOP_CPU      = 6,
  parameter int WAPUTYPE     = 3,
  parameter int NUSFLAGS_CPU = 5,
  parameter int NDSFLAGS_CPU = 15,
  parameter int WRESULT      = 32,
  parameter int WARG         = 32,
  parameter int NARGS_CPU    = 3
);
  logic                      cpu_req_ds_s_i;
  logic                      cpu_ack_ds_s_o;
  logic [WAPUTYPE-1:0]       cpu_type_ds_d_i;
  logic [NARGS_CPU*WARG-1:0] cpu_operands_ds_d_i;
  logic [WOP_CPU-1:0]        cpu_op_ds_d_i;
  logic [NDSFLAGS_CPU-1:0]   cpu_flags_ds_d_i;
  logic                      cpu_valid_us_s_o;
  logic                      cpu_ready_us_s_i;
  logic [WRESULT-1:0]        cpu_result_us_d_o;
  logic [NUSFLAGS_CPU-1:0]   cpu_flags_us_d_o;
  logic                      apu_req_o;
  logic                      apu_gnt_i;
  logic [WAPUTYPE-1:0]       apu_type_o;
  logic [NARGS_CPU*WARG-1:0] apu_operands_o;
  logic [WOP_CPU-1:0]        apu_op_o;
  logic [NDSFLAGS_CPU-1:0]   apu_flags_o;
  logic                      apu_rvalid_i;
  logic [WRESULT-1:0]        apu_result_i;
  logic [NUSFLAGS_CPU-1:0]   apu_flags_i;

  modport slave (
    input  cpu_req_ds_s_i, cpu_type_ds_d_i, cpu_operands_ds_d_i, cpu_op_ds_d_i, cpu_flags_ds_d_i,
    input  cpu_ready_us_s_i, apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
    output cpu_ack_ds_s_o, cpu_valid_us_s_o, cpu_result_us_d_o, cpu_flags_us_d_o,
    output apu_req_o, apu_type_o, apu_operands_o, apu_op_o, apu_flags_o
  );

  modport master (
    output cpu_req_ds_s_i, cpu_type_ds_d_i, cpu_operands_ds_d_i, cpu_op_ds_d_i, cpu_flags_ds_d_i,
    output cpu_ready_us_s_i, apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
    input  cpu_ack_ds_s_o, cpu_valid_us_s_o, cpu_result_us_d_o, cpu_flags_us_d_o,
    input  apu_req_o, apu_type_o, apu_operands_o, apu_op_o, apu_flags_o
  );
endinterface

// File: rtl/marx_cpu_req_buffer.sv
// Per-core request slot feeding the shared unit, with a credit-guarded in-order result FIFO back to the core.
// Credits cover slot + issued + queued requests, so every returning result always has a FIFO entry.
module marx_cpu_req_buffer #(
  parameter int WOP_CPU      = 6,
  parameter int WAPUTYPE     = 3,
  parameter int NUSFLAGS_CPU = 5,
  parameter int NDSFLAGS_CPU = 15,
  parameter int WRESULT      = 32,
  parameter int WARG         = 32,
  parameter int NARGS_CPU    = 3,
  parameter int RES_DEPTH    = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  marx_cpu_req_buffer_if.slave             bus,
  output logic [$clog2(RES_DEPTH+1)-1:0]   outstanding_o,
  output logic                             err_o
);
  localparam int CW  = $clog2(RES_DEPTH + 1);
  localparam int IFW = CW + 1;
  localparam int PW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} slot_state_t;

  slot_state_t               state_q, state_d;
  logic [WAPUTYPE-1:0]       type_q;
  logic [NARGS_CPU*WARG-1:0] operands_q;
  logic [WOP_CPU-1:0]        op_q;
  logic [NDSFLAGS_CPU-1:0]   flags_q;
  logic [CW-1:0]             outstanding_q, fifo_count_q;
  logic [PW-1:0]             rd_ptr_q, wr_ptr_q;
  logic [WRESULT-1:0]        res_mem [RES_DEPTH];
  logic [NUSFLAGS_CPU-1:0]   flg_mem [RES_DEPTH];
  logic                      err_q;

  logic [IFW-1:0] in_flight;
  logic           ack, issue, rvalid_ok, fifo_empty, fifo_full, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check uses registered state only; a pop in the same cycle frees nothing until next cycle.
  always_comb begin
    in_flight  = IFW'(state_q == PEND) + IFW'(outstanding_q) + IFW'(fifo_count_q);
    ack        = bus.cpu_req_ds_s_i & ((state_q == IDLE) | bus.apu_gnt_i) &
                 (in_flight < IFW'(RES_DEPTH));
    issue      = (state_q == PEND) & bus.apu_gnt_i;
    fifo_empty = (fifo_count_q == '0);
    fifo_full  = (fifo_count_q == CW'(RES_DEPTH));
    pop        = !fifo_empty & bus.cpu_ready_us_s_i;
    rvalid_ok  = bus.apu_rvalid_i & (outstanding_q != '0);
    push       = rvalid_ok & (!fifo_full | pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ack) state_d = PEND;
      PEND:    if (bus.apu_gnt_i && !ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      type_q     <= '0;
      operands_q <= '0;
      op_q       <= '0;
      flags_q    <= '0;
    end else if (ack) begin
      type_q     <= bus.cpu_type_ds_d_i;
      operands_q <= bus.cpu_operands_ds_d_i;
      op_q       <= bus.cpu_op_ds_d_i;
      flags_q    <= bus.cpu_flags_ds_d_i;
    end
  end

  // Any rvalid that cannot be pushed (nothing outstanding, or no room) is dropped and latched as an error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        res_mem[i] <= '0;
        flg_mem[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_q + CW'(issue) - CW'(rvalid_ok);
      fifo_count_q  <= fifo_count_q + CW'(push) - CW'(pop);
      if (push) begin
        res_mem[wr_ptr_q] <= bus.apu_result_i;
        flg_mem[wr_ptr_q] <= bus.apu_flags_i;
        wr_ptr_q          <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (bus.apu_rvalid_i && !push) err_q <= 1'b1;
    end
  end

  assign bus.cpu_ack_ds_s_o    = ack;
  assign bus.cpu_valid_us_s_o  = !fifo_empty;
  assign bus.cpu_result_us_d_o = fifo_empty ? '0 : res_mem[rd_ptr_q];
  assign bus.cpu_flags_us_d_o  = fifo_empty ? '0 : flg_mem[rd_ptr_q];
  assign bus.apu_req_o         = (state_q == PEND);
  assign bus.apu_type_o        = type_q;
  assign bus.apu_operands_o    = operands_q;
  assign bus.apu_op_o          = op_q;
  assign bus.apu_flags_o       = flags_q;
  assign outstanding_o         = outstanding_q;
  assign err_o                 = err_q;
endmodule

// File: tb/tb_marx_cpu_req_buffer.sv
// Directed scenario bench for marx_cpu_req_buffer (RES_DEPTH=2): inputs change at negedge, outputs checked #1 later.
module tb_marx_cpu_req_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] outstanding;
  logic       err;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  marx_cpu_req_buffer_if bus ();

  marx_cpu_req_buffer #(.RES_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave), .outstanding_o(outstanding), .err_o(err)
  );

  function automatic logic [95:0] exp_operands(input logic [5:0] op);
    return {32'h3000_0000 | 32'(op), 32'h2000_0000 | 32'(op), 32'h1000_0000 | 32'(op)};
  endfunction

  function automatic logic [14:0] exp_dsflags(input logic [5:0] op);
    return 15'(op) << 4;
  endfunction

  task automatic idle_inputs();
    bus.cpu_req_ds_s_i = 0; bus.cpu_type_ds_d_i = '0; bus.cpu_operands_ds_d_i = '0;
    bus.cpu_op_ds_d_i = '0; bus.cpu_flags_ds_d_i = '0; bus.cpu_ready_us_s_i = 0;
    bus.apu_gnt_i = 0; bus.apu_rvalid_i = 0; bus.apu_result_i = '0; bus.apu_flags_i = '0;
  endtask

  task automatic drive_req(input logic [5:0] op, input logic [2:0] typ);
    bus.cpu_req_ds_s_i = 1; bus.cpu_op_ds_d_i = op; bus.cpu_type_ds_d_i = typ;
    bus.cpu_operands_ds_d_i = exp_operands(op); bus.cpu_flags_ds_d_i = exp_dsflags(op);
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); rst = 1;
    @(negedge clk); #1;
    tests_run++; if (bus.apu_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_apu_req got %0b want 0", bus.apu_req_o); end
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %0b want 0", bus.cpu_valid_us_s_o); end
    tests_run++; if (outstanding !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_outstanding got %0d want 0", outstanding); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %0b want 0", err); end
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ack got %0b want 0", bus.cpu_ack_ds_s_o); end
    tests_run++; if (bus.apu_operands_o !== 96'd0 || bus.apu_op_o !== 6'd0) begin tests_failed++; $display("[TB] FAIL reset_payload got op=%h ops=%h want 0", bus.apu_op_o, bus.apu_operands_o); end
    rst = 0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk); bus.apu_gnt_i = 1; drive_req(6'h05, 3'd2); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_ack got %0b want 1", bus.cpu_ack_ds_s_o); end
    @(negedge clk); bus.cpu_req_ds_s_i = 0; #1;
    tests_run++; if (bus.apu_req_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_apu_req got %0b want 1", bus.apu_req_o); end
    tests_run++; if (bus.apu_op_o !== 6'h05 || bus.apu_type_o !== 3'd2) begin tests_failed++; $display("[TB] FAIL single_payload got op=%h type=%0d want op=05 type=2", bus.apu_op_o, bus.apu_type_o); end
    tests_run++; if (outstanding !== 2'd0) begin tests_failed++; $display("[TB] FAIL single_out_n1 got %0d want 0", outstanding); end
    @(negedge clk); #1;
    tests_run++; if (outstanding !== 2'd1) begin tests_failed++; $display("[TB] FAIL single_out_n2 got %0d want 1", outstanding); end
    tests_run++; if (bus.apu_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_apu_req_low got %0b want 0", bus.apu_req_o); end
    @(negedge clk); bus.apu_rvalid_i = 1; bus.apu_result_i = 32'h1234_5678; bus.apu_flags_i = 5'h0A; #1;
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_valid_early got %0b want 0", bus.cpu_valid_us_s_o); end
    @(negedge clk); bus.apu_rvalid_i = 0; #1;
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b1 || bus.cpu_result_us_d_o !== 32'h1234_5678 || bus.cpu_flags_us_d_o !== 5'h0A) begin tests_failed++; $display("[TB] FAIL single_result got v=%0b r=%h f=%h want v=1 r=12345678 f=0a", bus.cpu_valid_us_s_o, bus.cpu_result_us_d_o, bus.cpu_flags_us_d_o); end
    tests_run++; if (outstanding !== 2'd0) begin tests_failed++; $display("[TB] FAIL single_out_ret got %0d want 0", outstanding); end
    bus.cpu_ready_us_s_i = 1;
    @(negedge clk); bus.cpu_ready_us_s_i = 0; #1;
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_popped got %0b want 0", bus.cpu_valid_us_s_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); bus.apu_gnt_i = 1; drive_req(6'h01, 3'd1); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ack1 got %0b want 1", bus.cpu_ack_ds_s_o); end
    @(negedge clk); drive_req(6'h02, 3'd1); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ack2 got %0b want 1", bus.cpu_ack_ds_s_o); end
    @(negedge clk); drive_req(6'h03, 3'd1); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_ack3_full got %0b want 0", bus.cpu_ack_ds_s_o); end
    tests_run++; if (bus.apu_op_o !== 6'h02) begin tests_failed++; $display("[TB] FAIL b2b_pend_op got %h want 02", bus.apu_op_o); end
    @(negedge clk); bus.apu_rvalid_i = 1; bus.apu_result_i = 32'h0B0B_0001; bus.apu_flags_i = 5'h01; #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b0 || outstanding !== 2'd2) begin tests_failed++; $display("[TB] FAIL b2b_held_out2 got ack=%0b out=%0d want ack=0 out=2", bus.cpu_ack_ds_s_o, outstanding); end
    @(negedge clk); bus.apu_rvalid_i = 0; bus.cpu_ready_us_s_i = 1; #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_pop_no_credit got %0b want 0", bus.cpu_ack_ds_s_o); end
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b1 || bus.cpu_result_us_d_o !== 32'h0B0B_0001) begin tests_failed++; $display("[TB] FAIL b2b_result got v=%0b r=%h want v=1 r=0b0b0001", bus.cpu_valid_us_s_o, bus.cpu_result_us_d_o); end
    @(negedge clk); bus.cpu_ready_us_s_i = 0; #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ack3_late got %0b want 1", bus.cpu_ack_ds_s_o); end
    @(negedge clk); bus.cpu_req_ds_s_i = 0; #1;
    tests_run++; if (bus.apu_req_o !== 1'b1 || bus.apu_op_o !== 6'h03) begin tests_failed++; $display("[TB] FAIL b2b_issue3 got req=%0b op=%h want req=1 op=03", bus.apu_req_o, bus.apu_op_o); end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    @(negedge clk); drive_req(6'h2A, 3'd5); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_ack got %0b want 1", bus.cpu_ack_ds_s_o); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive_req(6'h15, 3'd3); #1;
      tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_ack_c%0d got %0b want 0", c, bus.cpu_ack_ds_s_o); end
      tests_run++; if (bus.apu_req_o !== 1'b1 || bus.apu_op_o !== 6'h2A || bus.apu_type_o !== 3'd5) begin tests_failed++; $display("[TB] FAIL stall_req_c%0d got req=%0b op=%h type=%0d want 1 2a 5", c, bus.apu_req_o, bus.apu_op_o, bus.apu_type_o); end
      tests_run++; if (bus.apu_operands_o !== exp_operands(6'h2A) || bus.apu_flags_o !== exp_dsflags(6'h2A)) begin tests_failed++; $display("[TB] FAIL stall_payload_c%0d got ops=%h fl=%h want ops=%h fl=%h", c, bus.apu_operands_o, bus.apu_flags_o, exp_operands(6'h2A), exp_dsflags(6'h2A)); end
    end
    @(negedge clk); bus.cpu_req_ds_s_i = 0; bus.apu_gnt_i = 1; #1;
    tests_run++; if (bus.apu_req_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_gnt_cycle got %0b want 1", bus.apu_req_o); end
    @(negedge clk); bus.apu_gnt_i = 0; #1;
    tests_run++; if (bus.apu_req_o !== 1'b0 || outstanding !== 2'd1) begin tests_failed++; $display("[TB] FAIL stall_after_gnt got req=%0b out=%0d want req=0 out=1", bus.apu_req_o, outstanding); end
  endtask

  task automatic test_fifo_order();
    do_reset();
    @(negedge clk); bus.apu_gnt_i = 1; drive_req(6'h06, 3'd0); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL fifo_ack1 got %0b want 1", bus.cpu_ack_ds_s_o); end
    @(negedge clk); drive_req(6'h07, 3'd0); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL fifo_ack2 got %0b want 1", bus.cpu_ack_ds_s_o); end
    @(negedge clk); bus.cpu_req_ds_s_i = 0;
    @(negedge clk); bus.apu_rvalid_i = 1; bus.apu_result_i = 32'hAAAA_0001; bus.apu_flags_i = 5'h01;
    @(negedge clk); bus.apu_result_i = 32'hAAAA_0002; bus.apu_flags_i = 5'h02; #1;
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b1 || bus.cpu_result_us_d_o !== 32'hAAAA_0001) begin tests_failed++; $display("[TB] FAIL fifo_first got v=%0b r=%h want v=1 r=aaaa0001", bus.cpu_valid_us_s_o, bus.cpu_result_us_d_o); end
    @(negedge clk); bus.apu_rvalid_i = 0; drive_req(6'h08, 3'd0); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL fifo_full_ack got %0b want 0", bus.cpu_ack_ds_s_o); end
    tests_run++; if (outstanding !== 2'd0 || bus.cpu_valid_us_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL fifo_full_state got out=%0d v=%0b want out=0 v=1", outstanding, bus.cpu_valid_us_s_o); end
    @(negedge clk); bus.cpu_req_ds_s_i = 0; bus.cpu_ready_us_s_i = 1; #1;
    tests_run++; if (bus.cpu_result_us_d_o !== 32'hAAAA_0001 || bus.cpu_flags_us_d_o !== 5'h01) begin tests_failed++; $display("[TB] FAIL fifo_pop1 got r=%h f=%h want r=aaaa0001 f=01", bus.cpu_result_us_d_o, bus.cpu_flags_us_d_o); end
    @(negedge clk); #1;
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b1 || bus.cpu_result_us_d_o !== 32'hAAAA_0002 || bus.cpu_flags_us_d_o !== 5'h02) begin tests_failed++; $display("[TB] FAIL fifo_pop2 got v=%0b r=%h f=%h want v=1 r=aaaa0002 f=02", bus.cpu_valid_us_s_o, bus.cpu_result_us_d_o, bus.cpu_flags_us_d_o); end
    @(negedge clk); bus.cpu_ready_us_s_i = 0; #1;
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL fifo_drained got v=%0b err=%0b want 0 0", bus.cpu_valid_us_s_o, err); end
  endtask

  task automatic test_err();
    do_reset();
    @(negedge clk); bus.apu_rvalid_i = 1; bus.apu_result_i = 32'h0000_DEAD; #1;
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_early got %0b want 0", err); end
    @(negedge clk); bus.apu_rvalid_i = 0; #1;
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_set got %0b want 1", err); end
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b0 || outstanding !== 2'd0) begin tests_failed++; $display("[TB] FAIL err_dropped got v=%0b out=%0d want v=0 out=0", bus.cpu_valid_us_s_o, outstanding); end
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_sticky got %0b want 1", err); end
    do_reset(); #1;
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_cleared got %0b want 0", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); bus.apu_gnt_i = 1; drive_req(6'h01, 3'd0);
    @(negedge clk); bus.cpu_req_ds_s_i = 0;
    @(negedge clk); bus.apu_gnt_i = 0; drive_req(6'h02, 3'd4); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1 || outstanding !== 2'd1) begin tests_failed++; $display("[TB] FAIL mid_setup got ack=%0b out=%0d want ack=1 out=1", bus.cpu_ack_ds_s_o, outstanding); end
    @(negedge clk); bus.cpu_req_ds_s_i = 0; rst = 1; bus.apu_rvalid_i = 1; bus.apu_result_i = 32'h0000_0055; #1;
    tests_run++; if (bus.apu_req_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_pend got %0b want 1", bus.apu_req_o); end
    @(negedge clk); rst = 0; bus.apu_rvalid_i = 0; #1;
    tests_run++; if (bus.apu_req_o !== 1'b0 || bus.apu_op_o !== 6'd0 || bus.apu_type_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL mid_slot got req=%0b op=%h type=%0d want 0", bus.apu_req_o, bus.apu_op_o, bus.apu_type_o); end
    tests_run++; if (outstanding !== 2'd0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_counts got out=%0d err=%0b want 0 0", outstanding, err); end
    tests_run++; if (bus.cpu_valid_us_s_o !== 1'b0 || bus.cpu_result_us_d_o !== 32'd0) begin tests_failed++; $display("[TB] FAIL mid_fifo got v=%0b r=%h want 0", bus.cpu_valid_us_s_o, bus.cpu_result_us_d_o); end
    drive_req(6'h03, 3'd0); #1;
    tests_run++; if (bus.cpu_ack_ds_s_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_credit got %0b want 1", bus.cpu_ack_ds_s_o); end
    @(negedge clk); bus.cpu_req_ds_s_i = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_gnt_stall();
    test_fifo_order();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end
endmodule
